rng_scheduler: RTL and testbench

Shares the single 8-bit LCG random stream between N_REQ requesters, such as game-logic blocks that need dice rolls or spawn positions. Each requester asks for a value in [0, limit). A round-robin arbiter picks one requester at a time. Range reduction uses mask-and-reject sampling on the free-running random word, with a bounded retry count. The block sits between the PRNG output and the consumers; it does not drive the PRNG.

---
 rtl/rng_scheduler.sv | 128 ++++++++++++
 tb/tb_rng_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rng_scheduler.sv
// Round-robin sharing of one free-running 8-bit random word among N_REQ requesters,
// each receiving a value in [0, limit) by mask-and-reject sampling with bounded retries.
module rng_scheduler #(
   parameter int N_REQ     = 4,
   parameter int MAX_TRIES = 4,
   localparam int IW       = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rnd,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   limit,
   output logic [N_REQ-1:0]     ack,
   output logic [7:0]           value,
   output logic [IW-1:0]        grant_id,
   output logic                 busy
);

   typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [7:0]    limit_q, limit_d;
   logic [7:0]    mask_q, mask_d;
   logic [7:0]    value_q, value_d;
   logic [3:0]    try_q, try_d;

   logic          found;
   logic [IW-1:0] pick;
   logic [7:0]    pick_limit;
   logic [7:0]    lm1, m1, m2, m3;
   logic [7:0]    samp;
   int            idx;

   // Rotating search for the first pending request at or above the pointer.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
      pick_limit = limit[8*int'(pick) +: 8];
      // Smearing limit-1 downward yields the smallest 2^k-1 covering it; limit=0 wraps to 0xFF.
      lm1 = pick_limit - 8'd1;
      m1  = lm1 | (lm1 >> 1);
      m2  = m1 | (m1 >> 2);
      m3  = m2 | (m2 >> 4);
   end

   assign samp = rnd & mask_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      limit_d = limit_q;
      mask_d  = mask_q;
      value_d = value_q;
      try_d   = try_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = pick;
               limit_d = pick_limit;
               mask_d  = m3;
               try_d   = 4'd0;
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (limit_q == 8'd0 || samp < limit_q) begin
               value_d = samp;
               state_d = S_DONE;
            end else if (try_q == 4'(MAX_TRIES - 1)) begin
               // mask < 2*limit, so the folded value is always in range.
               value_d = samp - limit_q;
               state_d = S_DONE;
            end else begin
               try_d = try_q + 4'd1;
            end
         end
         S_DONE: begin
            ptr_d   = (grant_q == IW'(N_REQ - 1)) ? '0 : IW'(grant_q + 1'b1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         limit_q <= 8'd0;
         mask_q  <= 8'd0;
         value_q <= 8'd0;
         try_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         limit_q <= limit_d;
         mask_q  <= mask_d;
         value_q <= value_d;
         try_q   <= try_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_ack
         assign ack[gi] = (state_q == S_DONE) && (grant_q == IW'(gi));
      end
   endgenerate

   assign value    = value_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rng_scheduler.sv
// Bench for rng_scheduler: directed scenarios plus randomized request traffic,
// checked against a transaction-level model of arbitration and range reduction.
module tb_rng_scheduler;
   localparam int N  = 4;
   localparam int MT = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     rnd;
   logic [N-1:0]   req_r;
   logic [8*N-1:0] limit_r;
   logic [N-1:0]   ack;
   logic [7:0]     value;
   logic [IW-1:0]  grant_id;
   logic           busy;

   int          n_checks = 0;
   int          n_errors = 0;
   int          m_ptr = 0;
   logic [7:0]  rseq [16];
   int          w, l;
   logic [7:0]  v;

   rng_scheduler #(.N_REQ(N), .MAX_TRIES(MT)) dut (
      .clk(clk), .rst(rst), .rnd(rnd), .req(req_r), .limit(limit_r),
      .ack(ack), .value(value), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int mask_of(input int lim);
      int m;
      if (lim == 0) return 255;
      m = 0;
      while (m < lim - 1) m = m * 2 + 1;
      return m;
   endfunction

   // Starts in an IDLE cycle just after a negedge; ends in the following IDLE cycle.
   task automatic txn(input logic [N-1:0] reqv, input bit mutate,
                      output int got_win, output logic [7:0] got_val, output int got_lat);
      int win, lim, mask, s, val, samples, idx, lat;
      if (reqv == '0) reqv[0] = 1'b1;
      check("idle_busy", busy, 0);
      check("idle_ack", ack, 0);
      req_r = reqv;
      rnd   = 8'($urandom);
      win = -1;
      for (int i = 0; i < N; i++) begin
         idx = (m_ptr + i) % N;
         if (win < 0 && reqv[idx]) win = idx;
      end
      lim = int'(limit_r[8*win +: 8]);
      mask = mask_of(lim);
      samples = 0;
      val = 0;
      for (int k = 0; k < MT; k++) begin
         s = int'(rseq[k]) & mask;
         samples = k + 1;
         if (lim == 0 || s < lim) begin
            val = s;
            break;
         end
         if (k == MT - 1) val = s - lim;
      end
      @(negedge clk);
      lat = 1;
      while (ack == '0 && lat <= MT + 2) begin
         check("samp_busy", busy, 1);
         rnd = rseq[lat-1];
         if (mutate) begin
            limit_r[8*win +: 8] = 8'($urandom);
            if ($urandom_range(1) == 1) req_r[win] = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      check("ack_lat", lat, samples + 1);
      check("ack_vec", ack, 1 << win);
      check("value", value, val);
      check("grant_id", grant_id, win);
      check("done_busy", busy, 1);
      got_win = -1;
      for (int i = 0; i < N; i++) if (ack[i]) got_win = i;
      got_val = value;
      got_lat = lat;
      req_r[win] = 1'b0;
      m_ptr = (win + 1) % N;
      rnd = 8'($urandom);
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] nb;
      rst = 1'b1; req_r = '0; limit_r = '0; rnd = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_value", value, 0);
      check("rst_grant", grant_id, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      limit_r[7:0] = 8'd10; rseq[0] = 8'd3;
      txn(4'b0001, 1'b0, w, v, l);
      check("t1_win", w, 0); check("t1_val", v, 3); check("t1_lat", l, 2);

      limit_r[15:8] = 8'd10; rseq[0] = 8'd12; rseq[1] = 8'd14; rseq[2] = 8'd7;
      txn(4'b0010, 1'b0, w, v, l);
      check("t2_win", w, 1); check("t2_val", v, 7); check("t2_lat", l, 4);

      limit_r[23:16] = 8'd9;
      for (int k = 0; k < 16; k++) rseq[k] = 8'd13;
      txn(4'b0100, 1'b0, w, v, l);
      check("t3_win", w, 2); check("t3_val", v, 4); check("t3_lat", l, 5);

      limit_r[7:0] = 8'd1; rseq[0] = 8'hFF;
      txn(4'b0001, 1'b0, w, v, l);
      check("lim1_val", v, 0);
      limit_r[15:8] = 8'd0; rseq[0] = 8'h5A;
      txn(4'b0010, 1'b0, w, v, l);
      check("lim0_val", v, 8'h5A); check("lim0_lat", l, 2);

      // Abort requester 3 mid-sample; pointer was 2 before the reset.
      req_r = 4'b1000; limit_r[31:24] = 8'd9;
      @(negedge clk);
      check("abort_pre_busy", busy, 1);
      rnd = 8'd13; rst = 1'b1; req_r = '0;
      @(negedge clk);
      check("abort_ack", ack, 0);
      check("abort_value", value, 0);
      check("abort_busy", busy, 0);
      check("abort_grant", grant_id, 0);
      rst = 1'b0; m_ptr = 0;
      @(negedge clk);
      check("abort_idle_busy", busy, 0);
      check("abort_idle_ack", ack, 0);
      limit_r[15:8] = 8'd10; rseq[0] = 8'd3;
      txn(4'b1010, 1'b0, w, v, l);
      check("ptr_restart_win", w, 1);
      limit_r[31:24] = 8'd10; rseq[0] = 8'd2;
      txn(4'b1000, 1'b0, w, v, l);
      check("r3_win", w, 3); check("r3_val", v, 2);

      rst = 1'b1; req_r = '0;
      @(negedge clk);
      rst = 1'b0; m_ptr = 0; limit_r = '0; rseq[0] = 8'hC8;
      txn(4'b1111, 1'b0, w, v, l);
      check("rr0_win", w, 0); check("rr0_val", v, 8'hC8);
      for (int i = 1; i < N; i++) begin
         txn(req_r, 1'b0, w, v, l);
         check("rr_win", w, i); check("rr_val", v, 8'hC8);
      end
      txn(4'b0010, 1'b0, w, v, l);
      check("only1_win", w, 1);
      txn(4'b0101, 1'b0, w, v, l);
      check("pair_first", w, 2);
      txn(req_r, 1'b0, w, v, l);
      check("pair_second", w, 0);

      for (int t = 0; t < 200; t++) begin
         for (int k = 0; k < 16; k++)
            rseq[k] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
         nb = N'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            if (nb[i] && !req_r[i]) begin
               case ($urandom_range(3))
                  0: limit_r[8*i +: 8] = 8'd0;
                  1: limit_r[8*i +: 8] = 8'd1;
                  2: limit_r[8*i +: 8] = 8'($urandom_range(2, 20));
                  default: limit_r[8*i +: 8] = 8'($urandom);
               endcase
            end
         end
         req_r = req_r | nb;
         txn(req_r, 1'($urandom_range(1)), w, v, l);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
